// File: rtl/ram_rw_ctrl.sv
// Pattern fill / readback controller for the dual-port RAM stage.
// Define RAM_RW_CHECK_EN to build the readback comparator; otherwise err/err_cnt are tied to 0.
module ram_rw_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   err_cnt
);

    localparam int unsigned      DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CntMax   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DrainMax = ADDR_W'(RD_LAT - 1);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        seed_q, seed_d;

    logic              wr_en_d, rd_en_d, busy_d, done_d;
    logic [ADDR_W-1:0] wr_addr_d, rd_addr_d;
    logic [DATA_W-1:0] wr_data_d;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [7:0] s);
        logic [31:0] sum;
        sum = 32'(a) + 32'(s);
        return DATA_W'(sum);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWrite;
                    cnt_d   = '0;
                end
            end
            StWrite: begin
                if (cnt_q == CntMax) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            StRead: begin
                if (cnt_q == CntMax) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                if (cnt_q == DrainMax) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                seed_d  = seed_q + 8'd1;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered copies of the decode of the next state.
        wr_en_d   = (state_d == StWrite);
        rd_en_d   = (state_d == StRead);
        wr_addr_d = wr_en_d ? cnt_d : '0;
        wr_data_d = wr_en_d ? pattern(cnt_d, seed_d) : '0;
        rd_addr_d = rd_en_d ? cnt_d : '0;
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            seed_q      <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            ram_wr_en   <= wr_en_d;
            ram_wr_addr <= wr_addr_d;
            ram_wr_data <= wr_data_d;
            ram_rd_en   <= rd_en_d;
            ram_rd_addr <= rd_addr_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

`ifdef RAM_RW_CHECK_EN
    localparam int unsigned LastTap = RD_LAT - 1;

    logic [RD_LAT-1:0]             vld_q;
    logic [RD_LAT-1:0][DATA_W-1:0] exp_q;
    logic                          err_q, err_d;
    logic [ADDR_W:0]               err_cnt_q, err_cnt_d;
    logic                          mismatch;

    assign mismatch = vld_q[LastTap] && (ram_rd_data != exp_q[LastTap]);

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (state_q == StIdle && start) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != (ADDR_W + 1)'(DEPTH)) begin
                err_cnt_d = err_cnt_q + (ADDR_W + 1)'(1);
            end
        end
    end

    // Tap 0 is loaded alongside the registered read; data returns RD_LAT cycles later.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vld_q     <= '0;
            exp_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            vld_q[0] <= ram_rd_en;
            exp_q[0] <= pattern(ram_rd_addr, seed_q);
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
            end
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^ram_rd_data;
    assign err            = 1'b0;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_ram_rw_ctrl.sv
// Scoreboard bench for ram_rw_ctrl: RAM model with readback corruption, expected-access queues.
module tb_ram_rw_ctrl;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned RD_LAT   = 2;
    localparam int          DEPTH    = 32;
    localparam int          PASS_LEN = 2 * DEPTH + RD_LAT;
`ifdef RAM_RW_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    logic              sys_clk, sys_rst, start;
    logic              ram_wr_en, ram_rd_en, busy, done, err;
    logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;
    logic [DATA_W-1:0] ram_wr_data, ram_rd_data;
    logic [ADDR_W:0]   err_cnt;

    ram_rw_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_cnt     (err_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int edge_idx = 0;
    always @(posedge sys_clk) edge_idx <= edge_idx + 1;

    // RAM model: registered writes, RD_LAT-cycle read pipe, optional per-address corruption.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] pipe [RD_LAT];
    bit                corrupt [DEPTH];

    always @(posedge sys_clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        pipe[0] <= ram_rd_en ? (mem[ram_rd_addr] ^ (corrupt[ram_rd_addr] ? 8'h5A : 8'h00)) : '0;
        for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rd_data = pipe[RD_LAT-1];

    typedef struct {int addr; int data;} wr_t;
    typedef struct {int edge_n; int err; int cnt;} done_t;
    wr_t   wq[$];
    int    rq[$];
    done_t dq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int seed_m   = 0;
    bit active   = 0;
    int e0       = 0;
    int done_edge = -10;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_idx);
        end
    endtask

    function automatic int pattern(input int a, input int s);
        return (a + s) % (1 << DATA_W);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (edge_idx < target) tick();
    endtask

    // Drive a one-cycle start; model decides whether the DUT should accept it.
    task automatic try_start();
        int  e, n;
        bit  acc;
        start = 1'b1;
        e     = edge_idx + 1;
        acc   = !active || (e >= done_edge + 2);
        if (acc) begin
            n = 0;
            for (int a = 0; a < DEPTH; a++) begin
                wq.push_back('{a, pattern(a, seed_m)});
                rq.push_back(a);
                n += int'(corrupt[a]);
            end
            e0        = e;
            done_edge = e + PASS_LEN;
            active    = 1'b1;
            dq.push_back('{done_edge, (CheckEn && n > 0) ? 1 : 0,
                           CheckEn ? ((n > DEPTH) ? DEPTH : n) : 0});
            seed_m = (seed_m + 1) % 256;
        end
        tick();
        start = 1'b0;
        if (acc) begin
            chk("busy_after_start", longint'(busy), 1);
            chk("err_cleared", longint'(err), 0);
            chk("err_cnt_cleared", longint'(err_cnt), 0);
        end
    endtask

    task automatic wait_done();
        int guard = 0;
        while (edge_idx < done_edge + 1 && guard < 500) begin
            tick();
            guard++;
        end
        chk("pass_budget", longint'(guard < 500), 1);
    endtask

    task automatic reset_dut();
        sys_rst = 1'b1;
        tick();
        active = 1'b0;
        wq.delete();
        rq.delete();
        dq.delete();
        seed_m = 0;
        chk("rst_wr_en", longint'(ram_wr_en), 0);
        chk("rst_wr_addr", longint'(ram_wr_addr), 0);
        chk("rst_wr_data", longint'(ram_wr_data), 0);
        chk("rst_rd_en", longint'(ram_rd_en), 0);
        chk("rst_rd_addr", longint'(ram_rd_addr), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_err", longint'(err), 0);
        chk("rst_err_cnt", longint'(err_cnt), 0);
        tick();
        sys_rst = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents an access or done.
    wr_t   mw;
    done_t md;
    int    mr;
    always @(negedge sys_clk) begin
        if (ram_wr_en || ram_rd_en)
            chk("port_exclusive", longint'(ram_wr_en & ram_rd_en), 0);
        if (ram_wr_en) begin
            if (wq.size() == 0) chk("unexpected_write", longint'(ram_wr_en), 0);
            else begin
                mw = wq.pop_front();
                chk("wr_addr", longint'(ram_wr_addr), mw.addr);
                chk("wr_data", longint'(ram_wr_data), mw.data);
            end
        end
        if (ram_rd_en) begin
            if (rq.size() == 0) chk("unexpected_read", longint'(ram_rd_en), 0);
            else begin
                mr = rq.pop_front();
                chk("rd_addr", longint'(ram_rd_addr), mr);
            end
        end
        if (done) begin
            if (dq.size() == 0) chk("unexpected_done", longint'(done), 0);
            else begin
                md = dq.pop_front();
                chk("done_edge", edge_idx, md.edge_n);
                chk("err_at_done", longint'(err), md.err);
                chk("err_cnt_at_done", longint'(err_cnt), md.cnt);
            end
        end
        chk("busy", longint'(busy),
            (active && edge_idx >= e0 && edge_idx <= done_edge) ? 1 : 0);
    end

    initial begin
        sys_rst = 1'b1;
        start   = 1'b0;
        for (int a = 0; a < DEPTH; a++) corrupt[a] = 1'b0;
        reset_dut();
        repeat (2) tick();

        // Basic pass with stray starts at cycles 10 and 40.
        try_start();
        wait_until(e0 + 9);
        try_start();
        wait_until(e0 + 39);
        try_start();
        wait_done();

        // Seed advance.
        try_start();
        wait_done();

        // Corrupt addresses 7 and 20, then a clean pass must clear err.
        corrupt[7]  = 1'b1;
        corrupt[20] = 1'b1;
        repeat (3) tick();
        try_start();
        wait_done();
        corrupt[7]  = 1'b0;
        corrupt[20] = 1'b0;
        try_start();
        wait_done();

        // Reset sampled mid-READ at cycle 45; next pass restarts from seed 0.
        try_start();
        wait_until(e0 + 44);
        reset_dut();
        repeat (5) tick();
        try_start();
        wait_done();

        // Randomized passes: random corruption, stray starts and gaps.
        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < DEPTH; a++) corrupt[a] = ($urandom_range(0, 7) == 0);
            try_start();
            for (int s = 0; s < 3; s++) begin
                wait_until(edge_idx + int'($urandom_range(1, 25)));
                if (edge_idx < done_edge) try_start();
            end
            wait_done();
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (5) tick();
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
